sram_controller: RTL and testbench
==================================

Name: sram_controller

Overview:
Multi-cycle data-memory back end for the MEM stage. It accepts the stage's 32-bit word read/write request (ALU result as address, valRm as write data) and executes it on an external 16-bit asynchronous SRAM as two half-word accesses. It drives `ready` low while busy; the hazard/freeze logic uses `ready` to stall the whole pipeline.

Parameters:
- WAIT_CYCLES, 2, clock cycles each half-word access is held on the SRAM pins (>=1)
- BASE_ADDR, 1024, CPU byte address mapped to SRAM word 0
- SRAM_AW, 18, SRAM address width

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-low
- memREn  in  1  read request from MEM stage
- memWEn  in  1  write request from MEM stage
- memAdr  in  32  CPU byte address (ALU result)
- writeData  in  32  store data (valRm)
- readData  out  32  load data returned to the MEM stage
- ready  out  1  0 = access in progress, freeze pipeline
- sramDQ  inout  16  SRAM data bus
- sramAddr  out  SRAM_AW  SRAM half-word address
- sramWeN  out  1  SRAM write enable, active-low
- sramOeN, sramCeN, sramUbN, sramLbN  out  1 each  tied 0

Behaviour:
- Reset (rst=0, async):
  - state=IDLE, counter=0, readData=0, sramWeN=1, sramAddr=0, sramDQ=Z.
  - Reset mid-access aborts it. A partial write may leave one half written; this is acceptable.
- States:
  - IDLE, RD_LO, RD_HI, WR_LO, WR_HI, DONE.
- Address mapping:
  - word = (memAdr - BASE_ADDR) >> 2, truncated to SRAM_AW-1 bits.
  - LO half address = {word, 1'b0}, holds bits [15:0].
  - HI half address = {word, 1'b1}, holds bits [31:16].
- ready (combinational):
  - 0 when state=IDLE and (memREn|memWEn).
  - 0 in RD_*/WR_*.
  - 1 in DONE, and 1 in IDLE with no request.
- Transitions:
  - IDLE: memWEn -> WR_LO; else memREn -> RD_LO. memWEn has priority if both are asserted.
  - *_LO: hold for WAIT_CYCLES cycles (counter 0..WAIT_CYCLES-1), then go to *_HI with counter reset.
  - *_HI: hold for WAIT_CYCLES cycles, then go to DONE.
  - DONE: one cycle, then IDLE unconditionally. The still-asserted request in DONE must not retrigger, because the pipeline advances on that edge.
- Read:
  - On the last cycle of RD_LO, register sramDQ into readData[15:0].
  - On the last cycle of RD_HI, register sramDQ into readData[31:16].
  - readData is valid in DONE and holds until the next read completes.
- Write:
  - sramDQ = writeData[15:0] in WR_LO and writeData[31:16] in WR_HI.
  - sramWeN=0 for all cycles of WR_LO/WR_HI.
  - Outside WR_*, sramDQ=Z and sramWeN=1.
- Latency:
  - ready is low for 1 + 2*WAIT_CYCLES cycles, then high for one cycle (DONE).
  - With the default WAIT_CYCLES=2: 5 low, 1 high.
- Input stability:
  - memAdr/writeData/enables must stay stable while ready=0 (the pipeline is frozen).
  - The block latches nothing from them except via the state machine.
- No request: the block stays in IDLE with ready=1 and zero added latency. Non-memory instructions never stall.

Decomposition:
- Shared package holds:
  - state enum
  - BASE_ADDR default
  - SRAM_AW
  - SRAM data width 16
- No RTL sub-module is needed.
- The bench uses a behavioural SRAM model named sram_model: 2^18 x 16, combinational read, write on sramWeN=0.

Test Plan:
- Reset with rst=0 mid-WR_LO (WAIT_CYCLES=2) -> immediately sramWeN=1, sramDQ=Z, readData=0, state IDLE; release with no request -> ready=1.
- Write memAdr=1024, writeData=0xDEADBEEF -> ready=0 for 5 cycles, then ready=1 for 1 cycle; SRAM[0]=0xBEEF, SRAM[1]=0xDEAD; sramWeN low for exactly 4 cycles.
- Read memAdr=1024 after the above -> ready=0 for 5 cycles; in DONE readData=0xDEADBEEF; sramWeN stays 1; DQ never driven.
- Write memAdr=1032, data 0x12345678 -> SRAM[4]=0x5678, SRAM[5]=0x1234.
- Back-to-back read 1032 immediately after DONE of the write -> no retrigger in DONE; a new access starts from IDLE and readData=0x12345678.
- memREn=memWEn=1, memAdr=1028, data 0xA5A5A5A5 -> write performed (SRAM[2]=SRAM[3]=0xA5A5); readData unchanged.
- Idle cycles with no request -> ready stays 1 for the whole run.

Source files
------------

// File: rtl/sram_controller_pkg.sv
// Shared definitions for the MEM-stage SRAM back end: FSM states and
// default geometry of the external 16-bit asynchronous SRAM.
package sram_controller_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD_LO,
    RD_HI,
    WR_LO,
    WR_HI,
    DONE
  } stateT;

  localparam int BASE_ADDR_DEFAULT = 1024;
  localparam int SRAM_AW_DEFAULT   = 18;
  localparam int SRAM_DW           = 16;

endpackage

// File: rtl/sram_controller.sv
// Executes a 32-bit word load/store as two half-word accesses on a 16-bit
// asynchronous SRAM, holding ready low so the pipeline freezes meanwhile.
module sram_controller
  import sram_controller_pkg::*;
#(
  parameter int WAIT_CYCLES = 2,
  parameter int BASE_ADDR   = BASE_ADDR_DEFAULT,
  parameter int SRAM_AW     = SRAM_AW_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 memREn,
  input  logic                 memWEn,
  input  logic [31:0]          memAdr,
  input  logic [31:0]          writeData,
  output logic [31:0]          readData,
  output logic                 ready,
  inout  wire  [SRAM_DW-1:0]   sramDQ,
  output logic [SRAM_AW-1:0]   sramAddr,
  output logic                 sramWeN,
  output logic                 sramOeN,
  output logic                 sramCeN,
  output logic                 sramUbN,
  output logic                 sramLbN
);

  localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(WAIT_CYCLES - 1);

  stateT              state;
  logic [CW-1:0]      counter;
  logic [SRAM_DW-1:0] dqOut;
  logic               dqEn;
  logic [31:0]        offset;
  logic [SRAM_AW-2:0] word;
  logic               lastCycle;
  logic               busy;
  logic               unusedBits;

  assign offset     = memAdr - 32'(BASE_ADDR);
  assign word       = offset[SRAM_AW:2];
  assign unusedBits = ^{offset[31:SRAM_AW+1], offset[1:0]};
  assign lastCycle  = (counter == LAST);

  assign busy  = (state == RD_LO) || (state == RD_HI) ||
                 (state == WR_LO) || (state == WR_HI) ||
                 ((state == IDLE) && (memREn || memWEn));
  assign ready = !busy;

  assign sramDQ  = dqEn ? dqOut : {SRAM_DW{1'bz}};
  assign sramOeN = 1'b0;
  assign sramCeN = 1'b0;
  assign sramUbN = 1'b0;
  assign sramLbN = 1'b0;

  // Pin-side outputs are set up on the edge that enters each state, so the
  // address and write data are already stable for every cycle of the hold.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      counter  <= '0;
      readData <= '0;
      sramWeN  <= 1'b1;
      sramAddr <= '0;
      dqOut    <= '0;
      dqEn     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          counter <= '0;
          if (memWEn) begin
            state    <= WR_LO;
            sramAddr <= {word, 1'b0};
            sramWeN  <= 1'b0;
            dqOut    <= writeData[15:0];
            dqEn     <= 1'b1;
          end else if (memREn) begin
            state    <= RD_LO;
            sramAddr <= {word, 1'b0};
          end
        end
        RD_LO: begin
          if (lastCycle) begin
            readData[15:0] <= sramDQ;
            state          <= RD_HI;
            counter        <= '0;
            sramAddr       <= {word, 1'b1};
          end else begin
            counter <= counter + 1'b1;
          end
        end
        RD_HI: begin
          if (lastCycle) begin
            readData[31:16] <= sramDQ;
            state           <= DONE;
            counter         <= '0;
          end else begin
            counter <= counter + 1'b1;
          end
        end
        WR_LO: begin
          if (lastCycle) begin
            state    <= WR_HI;
            counter  <= '0;
            sramAddr <= {word, 1'b1};
            dqOut    <= writeData[31:16];
          end else begin
            counter <= counter + 1'b1;
          end
        end
        WR_HI: begin
          if (lastCycle) begin
            state   <= DONE;
            counter <= '0;
            sramWeN <= 1'b1;
            dqEn    <= 1'b0;
          end else begin
            counter <= counter + 1'b1;
          end
        end
        // The request is still asserted here; returning to IDLE without
        // looking at it keeps the advancing instruction from re-issuing.
        DONE: begin
          state   <= IDLE;
          counter <= '0;
        end
        default: begin
          state   <= IDLE;
          counter <= '0;
          sramWeN <= 1'b1;
          dqEn    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sram_controller.sv
// Scoreboard bench for sram_controller against a behavioural 2^18 x 16
// asynchronous SRAM with combinational read.
module sram_model (
  input  logic [17:0] addr,
  inout  wire  [15:0] dq,
  input  logic        weN,
  input  logic        oeN,
  input  logic        ceN
);
  logic [15:0] mem [0:(1<<18)-1];

  assign dq = (!ceN && !oeN && weN) ? mem[addr] : 16'bz;

  always @(weN, addr, dq, ceN) begin
    if (!ceN && !weN) mem[addr] = dq;
  end
endmodule

module tb_sram_controller;

  typedef struct {
    logic [31:0] readData;
    int          lowCycles;
  } expT;

  logic        clk = 1'b0;
  logic        rst;
  logic        memREn;
  logic        memWEn;
  logic [31:0] memAdr;
  logic [31:0] writeData;
  logic [31:0] readData;
  logic        ready;
  wire  [15:0] sramDQ;
  logic [17:0] sramAddr;
  logic        sramWeN;
  logic        sramOeN;
  logic        sramCeN;
  logic        sramUbN;
  logic        sramLbN;

  int  compared   = 0;
  int  mismatched = 0;
  int  lowCnt     = 0;
  int  weLowCnt   = 0;
  expT expQ[$];

  always #5 clk = ~clk;

  sram_controller dut (
    .clk       (clk),
    .rst       (rst),
    .memREn    (memREn),
    .memWEn    (memWEn),
    .memAdr    (memAdr),
    .writeData (writeData),
    .readData  (readData),
    .ready     (ready),
    .sramDQ    (sramDQ),
    .sramAddr  (sramAddr),
    .sramWeN   (sramWeN),
    .sramOeN   (sramOeN),
    .sramCeN   (sramCeN),
    .sramUbN   (sramUbN),
    .sramLbN   (sramLbN)
  );

  sram_model uModel (
    .addr (sramAddr),
    .dq   (sramDQ),
    .weN  (sramWeN),
    .oeN  (sramOeN),
    .ceN  (sramCeN)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  // Monitor: a low-to-high return of ready marks a completed access.
  always @(negedge clk) begin
    if (!rst) begin
      lowCnt = 0;
    end else if (!ready) begin
      lowCnt++;
    end else if (lowCnt > 0) begin
      if (expQ.size() == 0) begin
        checkOutput("unexpectedDone", 32'(lowCnt), 32'd0);
      end else begin
        expT e;
        e = expQ.pop_front();
        checkOutput("readData", readData, e.readData);
        checkOutput("lowCycles", 32'(lowCnt), 32'(e.lowCycles));
      end
      lowCnt = 0;
    end
  end

  always @(negedge clk) begin
    if (!sramWeN) weLowCnt++;
  end

  task automatic applyStimulus(input logic we, input logic re, input logic [31:0] adr,
                               input logic [31:0] data, input logic [31:0] expRd);
    bit seenLow = 0;
    bit done    = 0;
    memWEn    = we;
    memREn    = re;
    memAdr    = adr;
    writeData = data;
    weLowCnt  = 0;
    expQ.push_back('{readData: expRd, lowCycles: 5});
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      if (!ready) seenLow = 1;
      else if (seenLow) done = 1;
    end
    if (!done) checkOutput("accessTimeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    memWEn = 1'b0;
    memREn = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b0; memREn = 1'b0; memWEn = 1'b0; memAdr = '0; writeData = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;

    // Abort a write in WR_LO with an asynchronous reset.
    memWEn = 1'b1; memAdr = 32'd1024; writeData = 32'h0BADF00D;
    @(posedge clk);
    #3 rst = 1'b0;
    #1;
    checkOutput("rstWeN", 32'(sramWeN), 32'd1);
    checkOutput("rstReadData", readData, 32'd0);
    memWEn = 1'b0;
    #1 checkOutput("rstReadyIdle", 32'(ready), 32'd1);
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk) checkOutput("postRstReady", 32'(ready), 32'd1);
    @(posedge clk); #1;

    applyStimulus(1'b1, 1'b0, 32'd1024, 32'hDEADBEEF, 32'h0);
    checkOutput("wr1Lo", 32'(uModel.mem[0]), 32'h0000BEEF);
    checkOutput("wr1Hi", 32'(uModel.mem[1]), 32'h0000DEAD);
    checkOutput("wr1WeLow", 32'(weLowCnt), 32'd4);

    applyStimulus(1'b0, 1'b1, 32'd1024, 32'h0, 32'hDEADBEEF);
    checkOutput("rd1WeLow", 32'(weLowCnt), 32'd0);

    applyStimulus(1'b1, 1'b0, 32'd1032, 32'h12345678, 32'hDEADBEEF);
    checkOutput("wr2Lo", 32'(uModel.mem[4]), 32'h00005678);
    checkOutput("wr2Hi", 32'(uModel.mem[5]), 32'h00001234);

    applyStimulus(1'b0, 1'b1, 32'd1032, 32'h0, 32'h12345678);

    applyStimulus(1'b1, 1'b1, 32'd1028, 32'hA5A5A5A5, 32'h12345678);
    checkOutput("wr3Lo", 32'(uModel.mem[2]), 32'h0000A5A5);
    checkOutput("wr3Hi", 32'(uModel.mem[3]), 32'h0000A5A5);
    checkOutput("wr3WeLow", 32'(weLowCnt), 32'd4);
    checkOutput("wr3KeepRd", readData, 32'h12345678);

    for (int i = 0; i < 10; i++) begin
      @(negedge clk) checkOutput("idleReady", 32'(ready), 32'd1);
    end

    checkOutput("queueDrained", 32'(expQ.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
